// File: rtl/gol_row_engine_if.sv
// Control, row-load and status bundle for gol_row_engine.
// The master side drives rows and requests; the slave side is the engine.
interface gol_row_engine_if #(
    parameter int HEIGHT = 18,
    parameter int WIDTH  = 18,
    parameter int GEN_W  = 16
);
    localparam int POP_W = $clog2(HEIGHT * WIDTH + 1);

    logic                      load_valid;
    logic                      load_ready;
    logic [WIDTH-1:0]          load_row;
    logic                      step;
    logic                      run;
    logic                      wrap;
    logic                      busy;
    logic                      gen_done;
    logic [GEN_W-1:0]          generation;
    logic [POP_W-1:0]          population;
    logic                      stable;
    logic [HEIGHT*WIDTH-1:0]   board;

    modport master (
        output load_valid, load_row, step, run, wrap,
        input  load_ready, busy, gen_done, generation, population, stable, board
    );

    modport slave (
        input  load_valid, load_row, step, run, wrap,
        output load_ready, busy, gen_done, generation, population, stable, board
    );
endinterface

// File: rtl/gol_row_engine.sv
// Row-serial Game of Life engine (B3/S23), one row per cycle into a shadow buffer, atomic commit.
// Latency: step at edge k -> board committed at edge k+HEIGHT+1; run mode yields one generation per HEIGHT+1 cycles.
// Backpressure: load_ready only in IDLE; step/load ignored while busy. GOL_AUTO_HALT_EN stops run on stable/empty boards.
module gol_row_engine #(
    parameter int HEIGHT = 18,
    parameter int WIDTH  = 18,
    parameter int GEN_W  = 16
) (
    input logic             clk,
    input logic             reset,
    gol_row_engine_if.slave bus
);
    localparam int CELLS  = HEIGHT * WIDTH;
    localparam int POP_W  = $clog2(CELLS + 1);
    localparam int RPOP_W = $clog2(WIDTH + 1);
    localparam int ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT} state_t;

    state_t             state_q, state_d;
    logic [CELLS-1:0]   board_q, board_d, shadow_q, shadow_d;
    logic [ROW_W-1:0]   load_ptr_q, load_ptr_d, row_ctr_q, row_ctr_d;
    logic [GEN_W-1:0]   gen_q, gen_d;
    logic [POP_W-1:0]   pop_q, pop_d, pend_q, pend_d;
    logic               stable_q, stable_d, gen_done_q, gen_done_d, wrap_q, wrap_d;
`ifdef GOL_AUTO_HALT_EN
    logic               armed_q, armed_d;
`endif

    logic [ROW_W-1:0]   r_up, r_dn;
    logic [WIDTH-1:0]   up_row, mid_row, dn_row, new_row;
    logic [WIDTH+1:0]   up_e, mid_e, dn_e;
    logic [3:0]         nbr;
    logic [RPOP_W-1:0]  new_pop, load_pop;
    logic               go, halt;

    function automatic logic [RPOP_W-1:0] popcount(input logic [WIDTH-1:0] row);
        logic [RPOP_W-1:0] n;
        n = '0;
        for (int c = 0; c < WIDTH; c++) n = n + RPOP_W'(row[c]);
        return n;
    endfunction

    // Pad a row with one cell each side: the opposite edge when toroidal, dead otherwise.
    function automatic logic [WIDTH+1:0] extend(input logic [WIDTH-1:0] row, input logic wr);
        return {wr & row[0], row, wr & row[WIDTH-1]};
    endfunction

    always_comb begin
        r_up    = (row_ctr_q == '0) ? ROW_W'(HEIGHT - 1) : row_ctr_q - 1'b1;
        r_dn    = (int'(row_ctr_q) == HEIGHT - 1) ? '0 : row_ctr_q + 1'b1;
        mid_row = board_q[int'(row_ctr_q)*WIDTH +: WIDTH];
        up_row  = board_q[int'(r_up)*WIDTH +: WIDTH];
        dn_row  = board_q[int'(r_dn)*WIDTH +: WIDTH];
        if (!wrap_q && row_ctr_q == '0) up_row = '0;
        if (!wrap_q && int'(row_ctr_q) == HEIGHT - 1) dn_row = '0;
        up_e    = extend(up_row, wrap_q);
        mid_e   = extend(mid_row, wrap_q);
        dn_e    = extend(dn_row, wrap_q);
        nbr     = '0;
        new_row = '0;
        for (int c = 0; c < WIDTH; c++) begin
            nbr = 4'(up_e[c]) + 4'(up_e[c+1]) + 4'(up_e[c+2])
                + 4'(mid_e[c]) + 4'(mid_e[c+2])
                + 4'(dn_e[c]) + 4'(dn_e[c+1]) + 4'(dn_e[c+2]);
            new_row[c] = (nbr == 4'd3) || (mid_row[c] && nbr == 4'd2);
        end
        new_pop  = popcount(new_row);
        load_pop = popcount(bus.load_row);
    end

    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        shadow_d   = shadow_q;
        load_ptr_d = load_ptr_q;
        row_ctr_d  = row_ctr_q;
        gen_d      = gen_q;
        pop_d      = pop_q;
        pend_d     = pend_q;
        stable_d   = stable_q;
        wrap_d     = wrap_q;
        gen_done_d = 1'b0;
        go         = 1'b0;
        halt       = 1'b0;
`ifdef GOL_AUTO_HALT_EN
        armed_d    = armed_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef GOL_AUTO_HALT_EN
                if (!bus.run) armed_d = 1'b1;
                go = bus.step || (bus.run && armed_q);
`else
                go = bus.step || bus.run;
`endif
                if (bus.load_valid) begin
                    board_d[int'(load_ptr_q)*WIDTH +: WIDTH] = bus.load_row;
                    load_ptr_d = (int'(load_ptr_q) == HEIGHT - 1) ? '0 : load_ptr_q + 1'b1;
                    gen_d      = '0;
                    stable_d   = 1'b0;
                    pop_d      = (load_ptr_q == '0) ? POP_W'(load_pop) : pop_q + POP_W'(load_pop);
                end else if (go) begin
                    wrap_d    = bus.wrap;
                    row_ctr_d = '0;
                    pend_d    = '0;
                    state_d   = COMPUTE;
                end
            end
            COMPUTE: begin
                shadow_d[int'(row_ctr_q)*WIDTH +: WIDTH] = new_row;
                pend_d = pend_q + POP_W'(new_pop);
                if (int'(row_ctr_q) == HEIGHT - 1) state_d = COMMIT;
                else row_ctr_d = row_ctr_q + 1'b1;
            end
            COMMIT: begin
                board_d    = shadow_q;
                stable_d   = (shadow_q == board_q);
                pop_d      = pend_q;
                gen_d      = gen_q + 1'b1;
                gen_done_d = 1'b1;
`ifdef GOL_AUTO_HALT_EN
                halt = stable_d || (pend_q == '0);
                if (halt) armed_d = 1'b0;
`endif
                if (bus.run && !halt) begin
                    wrap_d    = bus.wrap;
                    row_ctr_d = '0;
                    pend_d    = '0;
                    state_d   = COMPUTE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            board_q    <= '0;
            shadow_q   <= '0;
            load_ptr_q <= '0;
            row_ctr_q  <= '0;
            gen_q      <= '0;
            pop_q      <= '0;
            pend_q     <= '0;
            stable_q   <= 1'b0;
            gen_done_q <= 1'b0;
            wrap_q     <= 1'b0;
`ifdef GOL_AUTO_HALT_EN
            armed_q    <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            board_q    <= board_d;
            shadow_q   <= shadow_d;
            load_ptr_q <= load_ptr_d;
            row_ctr_q  <= row_ctr_d;
            gen_q      <= gen_d;
            pop_q      <= pop_d;
            pend_q     <= pend_d;
            stable_q   <= stable_d;
            gen_done_q <= gen_done_d;
            wrap_q     <= wrap_d;
`ifdef GOL_AUTO_HALT_EN
            armed_q    <= armed_d;
`endif
        end
    end

    assign bus.load_ready = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.gen_done   = gen_done_q;
    assign bus.generation = gen_q;
    assign bus.population = pop_q;
    assign bus.stable     = stable_q;
    assign bus.board      = board_q;
endmodule

// File: tb/tb_gol_row_engine.sv
// Scoreboard bench for gol_row_engine: an 18x18 instance plus a 4x5 instance with a 4-bit generation counter.
module tb_gol_row_engine;
    localparam int H = 18, W = 18, GW = 16;
    localparam int HB = 4, WB = 5, GWB = 4;
    localparam int CMAX = H * W;
    typedef bit [CMAX-1:0] brd_t;
    typedef struct { brd_t board; int pop; int gen; bit stable; } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic reset_b = 1'b0;
    always #5 clk = ~clk;

    gol_row_engine_if #(.HEIGHT(H),  .WIDTH(W),  .GEN_W(GW))  ifa ();
    gol_row_engine_if #(.HEIGHT(HB), .WIDTH(WB), .GEN_W(GWB)) ifb ();

    gol_row_engine #(.HEIGHT(H),  .WIDTH(W),  .GEN_W(GW))  dut_a (.clk(clk), .reset(reset),   .bus(ifa));
    gol_row_engine #(.HEIGHT(HB), .WIDTH(WB), .GEN_W(GWB)) dut_b (.clk(clk), .reset(reset_b), .bus(ifb));

    int   n_vec = 0, n_err = 0;
    exp_t qa[$], qb[$];
    brd_t ma_board, mb_board;
    int   ma_gen = 0, mb_gen = 0;

    // Reference generation from the B3/S23 rules, cell (r,c) at bit r*w+c.
    function automatic brd_t life(input brd_t b, input int h, input int w, input bit wr);
        brd_t nb;
        int cnt, rr, cc;
        nb = '0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr == 0 && dc == 0) continue;
                        rr = r + dr;
                        cc = c + dc;
                        if (wr) begin
                            rr = (rr + h) % h;
                            cc = (cc + w) % w;
                        end else if (rr < 0 || rr >= h || cc < 0 || cc >= w) begin
                            continue;
                        end
                        cnt += int'(b[rr*w+cc]);
                    end
                end
                nb[r*w+c] = (cnt == 3) || (b[r*w+c] && cnt == 2);
            end
        end
        return nb;
    endfunction

    function automatic void chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endfunction

    function automatic void chk_brd(input string name, input brd_t act, input brd_t req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endfunction

    function automatic void check_exp(input string tag, input exp_t e, input brd_t brd,
                                      input int pop, input int gen, input int st);
        chk_brd({tag, "_board"}, brd, e.board);
        chk({tag, "_population"}, pop, e.pop);
        chk({tag, "_generation"}, gen, e.gen);
        chk({tag, "_stable"}, st, int'(e.stable));
    endfunction

    function automatic exp_t advance_a(input bit wr);
        exp_t e;
        brd_t nb;
        nb = life(ma_board, H, W, wr);
        ma_gen++;
        e.board  = nb;
        e.pop    = $countones(nb);
        e.gen    = ma_gen % (1 << GW);
        e.stable = (nb == ma_board);
        ma_board = nb;
        return e;
    endfunction

    // Monitors: pop one expectation per gen_done pulse.
    always @(negedge clk) begin
        if (ifa.gen_done === 1'b1) begin
            if (qa.size() == 0) chk("a_unexpected_gen_done", 1, 0);
            else check_exp("a", qa.pop_front(), brd_t'(ifa.board), int'(ifa.population),
                           int'(ifa.generation), int'(ifa.stable));
        end
    end

    always @(negedge clk) begin
        brd_t bb;
        if (ifb.gen_done === 1'b1) begin
            bb = '0;
            bb[HB*WB-1:0] = ifb.board;
            if (qb.size() == 0) chk("b_unexpected_gen_done", 1, 0);
            else check_exp("b", qb.pop_front(), bb, int'(ifb.population),
                           int'(ifb.generation), int'(ifb.stable));
        end
    end

    task automatic wait_gen_a(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (ifa.gen_done !== 1'b1 && n < 200);
        chk(name, n, H + 1);
    endtask

    task automatic load_a(input brd_t b);
        chk("a_load_ready_idle", int'(ifa.load_ready), 1);
        for (int r = 0; r < H; r++) begin
            ifa.load_valid = 1'b1;
            ifa.load_row   = b[r*W +: W];
            @(posedge clk); #1;
        end
        ifa.load_valid = 1'b0;
        ma_board = b;
        ma_gen   = 0;
        chk("a_load_population", int'(ifa.population), $countones(b));
        chk("a_load_generation", int'(ifa.generation), 0);
        chk("a_load_stable", int'(ifa.stable), 0);
    endtask

    task automatic step_a(input bit wr);
        qa.push_back(advance_a(wr));
        ifa.wrap = wr;
        ifa.step = 1'b1;
        @(posedge clk); #1;
        ifa.step = 1'b0;
        wait_gen_a("a_step_latency");
        @(negedge clk); #1;
    endtask

    task automatic run_gens(input int n, input bit wr);
        exp_t e;
        int k;
        k = 0;
        for (int i = 0; i < n; i++) begin
            e = advance_a(wr);
            qa.push_back(e);
            k++;
`ifdef GOL_AUTO_HALT_EN
            if (e.stable || e.pop == 0) break;
`endif
        end
        ifa.wrap = wr;
        ifa.run  = 1'b1;
        @(posedge clk); #1;
        if (k == 1) ifa.run = 1'b0;
        for (int i = 0; i < k; i++) begin
            wait_gen_a("a_run_period");
            if (i == k - 2) ifa.run = 1'b0;
        end
        chk("a_run_idle_after", int'(ifa.busy), 0);
        @(negedge clk); #1;
    endtask

    function automatic brd_t rand_board(input int cells);
        brd_t b;
        b = '0;
        for (int i = 0; i < cells; i++) b[i] = ($urandom_range(2) == 0);
        return b;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        brd_t b, prev;
        exp_t e;
        int n;
        ifa.load_valid = 0; ifa.load_row = '0; ifa.step = 0; ifa.run = 0; ifa.wrap = 0;
        ifb.load_valid = 0; ifb.load_row = '0; ifb.step = 0; ifb.run = 0; ifb.wrap = 0;
        #2 reset = 1'b1; reset_b = 1'b1;
        #1;
        chk_brd("rst_board", brd_t'(ifa.board), '0);
        chk("rst_busy", int'(ifa.busy), 0);
        chk("rst_generation", int'(ifa.generation), 0);
        chk("rst_population", int'(ifa.population), 0);
        chk("rst_stable", int'(ifa.stable), 0);
        chk("rst_gen_done", int'(ifa.gen_done), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; reset_b = 1'b0;
        #1 chk("rst_load_ready", int'(ifa.load_ready), 1);
        ma_board = '0;
        mb_board = '0;

        // Blinker in the middle of the board.
        b = '0;
        for (int c = 8; c <= 10; c++) b[9*W+c] = 1'b1;
        load_a(b);
        step_a(1'b0);
        step_a(1'b0);

        // Top edge, dead border then toroidal.
        b = '0;
        for (int c = 5; c <= 7; c++) b[c] = 1'b1;
        load_a(b);
        step_a(1'b0);
        step_a(1'b0);
        load_a(b);
        step_a(1'b1);
        step_a(1'b1);
        chk_brd("a_wrap_blinker_restored", brd_t'(ifa.board), b);

        for (int it = 0; it < 6; it++) begin
            load_a(rand_board(CMAX));
            n = $urandom_range(3, 1);
            for (int s = 0; s < n; s++) step_a(1'($urandom_range(1)));
        end

        // Still-life block under run.
        b = '0;
        b[4*W+4] = 1; b[4*W+5] = 1; b[5*W+4] = 1; b[5*W+5] = 1;
        load_a(b);
        run_gens(3, 1'b0);
        load_a(rand_board(CMAX));
        run_gens(4, 1'($urandom_range(1)));

        // Load, step and wrap change while busy must not disturb the generation in flight.
        load_a(rand_board(CMAX));
        prev = ma_board;
        qa.push_back(advance_a(1'b1));
        ifa.wrap = 1'b1;
        ifa.step = 1'b1;
        @(posedge clk); #1;
        ifa.step = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        ifa.wrap       = 1'b0;
        ifa.load_valid = 1'b1;
        ifa.load_row   = W'($urandom);
        ifa.step       = 1'b1;
        chk("a_busy_load_ready", int'(ifa.load_ready), 0);
        chk("a_busy_flag", int'(ifa.busy), 1);
        chk_brd("a_busy_board_held", brd_t'(ifa.board), prev);
        repeat (2) begin @(posedge clk); #1; end
        ifa.step       = 1'b0;
        ifa.load_valid = 1'b0;
        n = 0;
        while (ifa.gen_done !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        chk("a_busy_gen_done_seen", int'(ifa.gen_done === 1'b1), 1);
        repeat (2 * (H + 1)) @(posedge clk);
        #1;
        chk("a_busy_single_generation", int'(ifa.generation), 1);
        chk("a_busy_queue_drained", qa.size(), 0);

        // Reset in the middle of COMPUTE drops the partial generation.
        ifa.step = 1'b1;
        @(posedge clk); #1;
        ifa.step = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk_brd("a_midrst_board", brd_t'(ifa.board), '0);
        chk("a_midrst_busy", int'(ifa.busy), 0);
        chk("a_midrst_generation", int'(ifa.generation), 0);
        chk("a_midrst_population", int'(ifa.population), 0);
        @(negedge clk);
        reset = 1'b0;
        ma_board = '0;
        ma_gen   = 0;
        #1 chk("a_midrst_load_ready", int'(ifa.load_ready), 1);
        repeat (H + 5) @(posedge clk);
        #1 chk("a_midrst_idle", int'(ifa.busy), 0);
        step_a(1'b0);

        // Small instance: 16 generations wrap the 4-bit counter to zero.
        b = rand_board(HB * WB);
        for (int r = 0; r < HB; r++) begin
            ifb.load_valid = 1'b1;
            ifb.load_row   = b[r*WB +: WB];
            @(posedge clk); #1;
        end
        ifb.load_valid = 1'b0;
        mb_board = b;
        chk("b_load_population", int'(ifb.population), $countones(b));
        for (int s = 0; s < 16; s++) begin
            ifb.wrap = 1'($urandom_range(1));
            mb_gen++;
            e.board  = life(mb_board, HB, WB, ifb.wrap);
            e.pop    = $countones(e.board);
            e.gen    = mb_gen % (1 << GWB);
            e.stable = (e.board == mb_board);
            mb_board = e.board;
            qb.push_back(e);
            ifb.step = 1'b1;
            @(posedge clk); #1;
            ifb.step = 1'b0;
            n = 0;
            do begin @(posedge clk); #1; n++; end while (ifb.gen_done !== 1'b1 && n < 100);
            chk("b_step_latency", n, HB + 1);
            @(negedge clk); #1;
        end
        chk("b_generation_wrapped", int'(ifb.generation), 0);

        repeat (4) @(posedge clk);
        #1;
        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
